// File: rtl/full_adder_16_pkg.sv
// Shared types for the 16-bit ripple adder and its result register.
package full_adder_16_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef logic [DEFAULT_WIDTH-1:0] word_t;

    // Registered adder result: sum plus the two flags that travel with it.
    typedef struct packed {
        word_t sum;
        logic  cout;
        logic  ovf;
    } result_t;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full-adder cell; the building block of the ripple chain.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    // Propagate term shared by the sum and the carry.
    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/full_adder_16.sv
// Ripple-carry adder with a combinational sum path and a one-cycle
// registered result stage that captures sum/carry/overflow on in_valid.
module full_adder_16
    import full_adder_16_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic [WIDTH-1:0] s_q,
    output logic             cout_q,
    output logic             ovf_q,
    output logic             out_valid
);

    // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0] c;
    logic           vld_q;

    assign c[0] = cin;

    // Ripple chain: one full-adder cell per bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_bit u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[WIDTH];
    // Signed overflow: carry into the MSB disagrees with carry out of it.
    assign ovf  = c[WIDTH-1] ^ c[WIDTH];

    // Valid flag follows in_valid by one cycle; cleared at once by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= 1'b0;
        else        vld_q <= in_valid;
    end

    assign out_valid = vld_q;

    if (WIDTH == DEFAULT_WIDTH) begin : g_res16
        result_t r_q;

        // Capture the combinational result on in_valid, hold otherwise.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)        r_q <= '0;
            else if (in_valid) r_q <= '{sum: s, cout: cout, ovf: ovf};
        end

        assign s_q    = r_q.sum;
        assign cout_q = r_q.cout;
        assign ovf_q  = r_q.ovf;
    end else begin : g_resn
        // Non-default widths cannot use the fixed-width package struct.
        logic [WIDTH+1:0] r_q;

        // Capture the combinational result on in_valid, hold otherwise.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)        r_q <= '0;
            else if (in_valid) r_q <= {s, cout, ovf};
        end

        assign s_q    = r_q[WIDTH+1:2];
        assign cout_q = r_q[1];
        assign ovf_q  = r_q[0];
    end

endmodule

// File: tb/tb_full_adder_16.sv
// Self-checking bench for full_adder_16: directed corner cases plus a
// randomized sweep against an arithmetic reference model.
module tb_full_adder_16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a, b;
    logic        cin, in_valid;
    logic [15:0] s, s_q;
    logic        cout, ovf, cout_q, ovf_q, out_valid;

    int checks = 0;
    int errors = 0;

    full_adder_16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .s_q       (s_q),
        .cout_q    (cout_q),
        .ovf_q     (ovf_q),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Reference: full unsigned sum and signed overflow from integer arithmetic.
    function automatic logic [16:0] ref_sum(input logic [15:0] x, input logic [15:0] y, input logic ci);
        int unsigned t;
        t = int'(x) + int'(y) + (ci ? 1 : 0);
        return t[16:0];
    endfunction

    function automatic logic ref_ovf(input logic [15:0] x, input logic [15:0] y, input logic ci);
        int t;
        t = int'($signed(x)) + int'($signed(y)) + (ci ? 1 : 0);
        return (t > 32767) || (t < -32768);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({s_q, cout_q, ovf_q, out_valid} !== 19'h0) begin
            errors++;
            $display("FAIL reset_state: got s_q=%h cout_q=%b ovf_q=%b out_valid=%b, want all 0", s_q, cout_q, ovf_q, out_valid);
        end
        checks++;
        if (s !== 16'h3333) begin
            errors++;
            $display("FAIL reset_comb: got s=%h want 3333", s);
        end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
    endtask

    task automatic test_basic();
        @(negedge clk);
        a = 16'h0003; b = 16'h0004; cin = 1'b0; in_valid = 1'b1;
        #1;
        checks++;
        if ({cout, ovf, s} !== {1'b0, 1'b0, 16'h0007}) begin
            errors++;
            $display("FAIL basic_comb: got s=%h cout=%b ovf=%b want 0007 0 0", s, cout, ovf);
        end
        @(posedge clk); #1;
        checks++;
        if (s_q !== 16'h0007 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_reg: got s_q=%h out_valid=%b want 0007 1", s_q, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0; a = 16'h0100;
        @(posedge clk); #1;
        checks++;
        if (s_q !== 16'h0007 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_one_cycle: got s_q=%h out_valid=%b want 0007 0", s_q, out_valid);
        end
    endtask

    task automatic test_wrap_and_overflow();
        logic [15:0] ta [4] = '{16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000};
        logic [15:0] tb [4] = '{16'h0001, 16'hFFFF, 16'h0001, 16'h8000};
        logic        tc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [15:0] es [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h0000};
        logic        ec [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic        eo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = ta[i]; b = tb[i]; cin = tc[i]; in_valid = 1'b1;
            #1;
            checks++;
            if (s !== es[i] || cout !== ec[i] || ovf !== eo[i]) begin
                errors++;
                $display("FAIL corner_comb[%0d]: got s=%h cout=%b ovf=%b want %h %b %b", i, s, cout, ovf, es[i], ec[i], eo[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (s_q !== es[i] || cout_q !== ec[i] || ovf_q !== eo[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL corner_reg[%0d]: got s_q=%h cout_q=%b ovf_q=%b vld=%b want %h %b %b 1", i, s_q, cout_q, ovf_q, out_valid, es[i], ec[i], eo[i]);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (s_q !== 16'h2345 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: got s_q=%h out_valid=%b want 2345 1", s_q, out_valid);
        end
        @(negedge clk);
        a = 16'hABCD; b = 16'h0000;
        @(posedge clk); #1;
        checks++;
        if (s_q !== 16'hABCD || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: got s_q=%h out_valid=%b want abcd 1", s_q, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0; a = 16'h0F0F;
        @(posedge clk); #1;
        checks++;
        if (s_q !== 16'hABCD || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_hold: got s_q=%h out_valid=%b want abcd 0", s_q, out_valid);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a = 16'h8001; b = 16'h8002; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || s_q !== 16'h0004 || cout_q !== 1'b1 || ovf_q !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: got s_q=%h cout_q=%b ovf_q=%b vld=%b want 0004 1 1 1", s_q, cout_q, ovf_q, out_valid);
        end
        #1 rst_n = 1'b0;   // mid-high phase, no clock edge nearby
        #1;
        checks++;
        if ({s_q, cout_q, ovf_q, out_valid} !== 19'h0) begin
            errors++;
            $display("FAIL areset_clear: got s_q=%h cout_q=%b ovf_q=%b vld=%b want all 0", s_q, cout_q, ovf_q, out_valid);
        end
        a = 16'h0005; b = 16'h0006; cin = 1'b0;
        #1;
        checks++;
        if (s !== 16'h000B || cout !== 1'b0) begin
            errors++;
            $display("FAIL areset_comb: got s=%h cout=%b want 000b 0", s, cout);
        end
        @(negedge clk);
        rst_n = 1'b1; a = 16'h0010; b = 16'h0020;
        @(posedge clk); #1;
        checks++;
        if (s_q !== 16'h0030 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_first_capture: got s_q=%h vld=%b want 0030 1", s_q, out_valid);
        end
    endtask

    task automatic test_random();
        logic [16:0] exp_full;
        logic        exp_o;
        logic [15:0] q_s = s_q;
        logic        q_c = cout_q;
        logic        q_o = ovf_q;
        logic        q_v;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            a        = 16'($urandom);
            b        = 16'($urandom);
            cin      = 1'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            #1;
            exp_full = ref_sum(a, b, cin);
            exp_o    = ref_ovf(a, b, cin);
            checks++;
            if ({cout, s} !== exp_full || ovf !== exp_o) begin
                errors++;
                $display("FAIL rand_comb[%0d]: a=%h b=%h cin=%b got {cout,s}=%h ovf=%b want %h %b", n, a, b, cin, {cout, s}, ovf, exp_full, exp_o);
            end
            if (in_valid) begin
                q_s = exp_full[15:0]; q_c = exp_full[16]; q_o = exp_o;
            end
            q_v = in_valid;
            @(posedge clk); #1;
            checks++;
            if (s_q !== q_s || cout_q !== q_c || ovf_q !== q_o || out_valid !== q_v) begin
                errors++;
                $display("FAIL rand_reg[%0d]: got s_q=%h cout_q=%b ovf_q=%b vld=%b want %h %b %b %b", n, s_q, cout_q, ovf_q, out_valid, q_s, q_c, q_o, q_v);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap_and_overflow();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
